id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter CTRL_W, default 14, width of the control-unit signal bundle.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 id_valid  input  1  decode stage holds a valid instruction.
REQ-006 id_signals  input  CTRL_W  control bundle from the control unit (bit3 MemToReg, bit4 RegWrite, bit5 MemRead, bit6 MemWrite, bit7 Branch).
REQ-007 id_pc, id_rs1_data, id_rs2_data, id_imm  input  XLEN each  decode-stage operands.
REQ-008 id_rs1, id_rs2, id_rd  input  5 each  register addresses; id_funct  input  4  {funct7[5],funct3}.
REQ-009 id_uses_rs1, id_uses_rs2  input  1 each  instruction reads that source.
REQ-010 flush  input  1  taken branch/jump resolved in EX; kill decode-stage instruction.
REQ-011 hold  input  1  downstream not ready; freeze this stage.
REQ-012 ex_valid  output  1; ex_signals  output  CTRL_W; ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  output  XLEN; ex_rs1, ex_rs2, ex_rd  output  5; ex_funct  output  4 -- registered EX-stage copies.
REQ-013 stall  output  1  combinational request to freeze PC and IF/ID register.

Function
REQ-014 Load-use hazard SHALL be: ex_valid & ex_signals[5] & ex_rd!=0 & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-015 stall SHALL equal (load-use hazard & ~flush) | hold.
REQ-016 Priority per edge SHALL be: reset > hold > flush > load-use > normal.
REQ-017 hold: all registers SHALL keep their value, including during flush or hazard.
REQ-018 flush (no hold): ex_valid<=0, ex_signals<=0; datapath fields don't-care.
REQ-019 load-use (no hold/flush): bubble -- ex_valid<=0, ex_signals<=0; decode instruction re-presented next cycle.
REQ-020 normal: every ex_* field SHALL capture its id_* counterpart; ex_valid<=id_valid; ex_signals<=id_valid ? id_signals : 0.
REQ-021 Latency SHALL be exactly one cycle id_* -> ex_* when not stalled.
REQ-022 ex_signals SHALL be all-zero whenever ex_valid=0 (invariant).
REQ-023 Hazard with ex_rd=0 SHALL NOT stall.
REQ-024 Back-to-back load-use: after one bubble the hazard clears (EX holds bubble), so stall SHALL last exactly one cycle per hazard.

Reset
REQ-025 On reset all outputs registers SHALL be zero: ex_valid=0, ex_signals=0, all data/address fields 0; stall follows REQ-015 with ex_valid=0.
REQ-026 Reset mid-hold or mid-stall SHALL override and clear as REQ-025.

Configuration
REQ-027 Macro ID_EX_PERF_CNT_EN defined: SHALL add outputs bubble_cnt and flush_cnt (32 bits each), incremented on each load-use bubble / each flush that kills a valid id instruction, not incremented under hold, wrap at 2^32, cleared by reset.
REQ-028 Macro undefined: counters and ports SHALL be absent; behaviour otherwise identical.

Structure
REQ-029 Opcode constants, control-bundle bit indices (MEMREAD_BIT=5 etc.), CTRL_W and XLEN SHALL live in shared package riscv_pkg.
REQ-030 Hazard comparator SHALL be sub-module hazard_detect (combinational, ex/id fields in, load_use out); pipeline register stays in id_ex_stage.

Verification
REQ-031 Normal: id_valid=1, id_signals=14'b00001000010000, id_rd=5, id_pc=0x100 -> next cycle ex_valid=1, ex_signals equal, ex_rd=5, ex_pc=0x100; stall=0.
REQ-032 Load-use: EX holds load (signals 14'b00000000111100, rd=7), id rs1=7 uses_rs1=1 -> stall=1 one cycle, next ex_valid=0, ex_signals=0, then instruction enters EX.
REQ-033 rd=0 load, id rs1=0 -> stall=0, instruction proceeds.
REQ-034 flush with concurrent load-use -> stall=0, next ex_valid=0; with ID_EX_PERF_CNT_EN, flush_cnt+1, bubble_cnt unchanged.
REQ-035 hold=1 three cycles with changing id_* -> ex_* constant, stall=1; hold released -> capture resumes.
REQ-036 reset asserted during hold with ex_valid=1 -> next cycle all ex_* zero, counters zero.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions.
// Contents: default datapath / control-bundle widths, register-address width,
// control-bundle bit positions and base opcode constants used by the ID/EX
// stage and its hazard comparator.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned CTRL_W     = 14;
    localparam int unsigned REG_ADDR_W = 5;

    // Control-bundle bit positions
    localparam int unsigned MEMTOREG_BIT = 3;
    localparam int unsigned REGWRITE_BIT = 4;
    localparam int unsigned MEMREAD_BIT  = 5;
    localparam int unsigned MEMWRITE_BIT = 6;
    localparam int unsigned BRANCH_BIT   = 7;

    // Base opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator (purely combinational).
// Ports:
//   ex_valid, ex_memread, ex_rd      - instruction currently in EX
//   id_valid, id_uses_rs1/2, id_rs1/2 - instruction currently in decode
//   load_use                         - decode instruction needs a value the
//                                      EX load has not produced yet
module hazard_detect
    import riscv_pkg::*;
(
    input  logic                  ex_valid,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  id_valid,
    input  logic                  id_uses_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    output logic                  load_use
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);

    // x0 is never a real dependency
    assign load_use = ex_valid && ex_memread && (ex_rd != '0) && id_valid
                      && (rs1_match || rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion.
// Ports:
//   clk, reset (synchronous, active-high)
//   id_*         - decode-stage instruction fields
//   flush        - kill the decode-stage instruction (taken branch in EX)
//   hold         - freeze this stage (downstream not ready)
//   ex_*         - registered EX-stage copies
//   stall        - combinational request to freeze PC and IF/ID
//   bubble_cnt, flush_cnt - only when ID_EX_PERF_CNT_EN is defined
// Priority per edge: reset > hold > flush > load-use > normal capture.
module id_ex_stage #(
    parameter int unsigned XLEN   = riscv_pkg::XLEN,
    parameter int unsigned CTRL_W = riscv_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_signals,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [3:0]        id_funct,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              flush,
    input  logic              hold,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_signals,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [3:0]        ex_funct,
    output logic              stall
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    import riscv_pkg::*;

    logic load_use;
    logic kill;

    hazard_detect u_hazard_detect (
        .ex_valid    (ex_valid),
        .ex_memread  (ex_signals[MEMREAD_BIT]),
        .ex_rd       (ex_rd),
        .id_valid    (id_valid),
        .id_uses_rs1 (id_uses_rs1),
        .id_rs1      (id_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .id_rs2      (id_rs2),
        .load_use    (load_use)
    );

    // A flush makes the hazard moot: the dependent instruction is gone.
    assign stall = (load_use && !flush) || hold;
    assign kill  = flush || load_use;

    // Datapath fields are captured even when killed; they are don't-care
    // while ex_valid is low, and skipping the mux keeps the register simple.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_signals  <= '0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct    <= '0;
        end else if (!hold) begin
            ex_valid    <= id_valid && !kill;
            ex_signals  <= (id_valid && !kill) ? id_signals : '0;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_funct    <= id_funct;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    // Flush takes precedence, so a flushed hazard counts as a flush only.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (!hold) begin
            if (flush) begin
                if (id_valid) begin
                    flush_cnt <= flush_cnt + 32'd1;
                end
            end else if (load_use) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
